// File: rtl/hv_alu_pkg.sv
// Shared op codes, FSM states and default sizing for the iterative hypervector ALU.
package hv_alu_pkg;

   localparam int HV_DIM_DEFAULT   = 512;
   localparam int ITER_MAX_DEFAULT = 16;

   typedef enum logic [2:0] {
      OP_XOR    = 3'd0,
      OP_PASS_A = 3'd1,
      OP_PASS_B = 3'd2,
      OP_ROR    = 3'd3,
      OP_ROL    = 3'd4,
      OP_AND    = 3'd5,
      OP_OR     = 3'd6,
      OP_NOT    = 3'd7
   } hv_alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } hv_alu_state_e;

endpackage

// File: rtl/hv_barrel_rot.sv
// Combinational circular rotator, one stage per shift-amount bit.
// dir=1 rotates left, dir=0 rotates right; amount 0 is identity.
module hv_barrel_rot #(
   parameter int HVDimension = 512,
   parameter int ShiftWidth  = $clog2(HVDimension)
) (
   input  logic [HVDimension-1:0] data,
   input  logic [ShiftWidth-1:0]  amt,
   input  logic                   dir,
   output logic [HVDimension-1:0] rot
);

   logic [ShiftWidth:0][HVDimension-1:0] stage;

   assign stage[0] = data;

   for (genvar k = 0; k < ShiftWidth; k++) begin : g_stage
      // 2**k stays below HVDimension for every k, so both shift terms are in range
      localparam int Amt = 2 ** k;
      logic [HVDimension-1:0] rot_l;
      logic [HVDimension-1:0] rot_r;

      assign rot_l = (stage[k] << Amt) | (stage[k] >> (HVDimension - Amt));
      assign rot_r = (stage[k] >> Amt) | (stage[k] << (HVDimension - Amt));
      assign stage[k+1] = amt[k] ? (dir ? rot_l : rot_r) : stage[k];
   end

   assign rot = stage[ShiftWidth];

endmodule

// File: rtl/hv_alu_iter_pe.sv
// Iterative hypervector ALU: captures A/B, applies one op iter+1 times with feedback into A,
// then holds the result under a valid/ready handshake (back-to-back accept from DONE).
module hv_alu_iter_pe
   import hv_alu_pkg::*;
#(
   parameter int HVDimension = HV_DIM_DEFAULT,
   parameter int NumOps      = 8,
   parameter int NumOpsWidth = $clog2(NumOps),
   parameter int ShiftWidth  = $clog2(HVDimension),
   parameter int IterMax     = ITER_MAX_DEFAULT,
   parameter int IterWidth   = $clog2(IterMax)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic [HVDimension-1:0] A_i,
   input  logic [HVDimension-1:0] B_i,
   input  logic [NumOpsWidth-1:0] op_i,
   input  logic [ShiftWidth-1:0]  shift_amt_i,
   input  logic [IterWidth-1:0]   iter_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   output logic [HVDimension-1:0] C_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i
);

   hv_alu_state_e          state_q;
   logic [HVDimension-1:0] acc_q;
   logic [HVDimension-1:0] b_q;
   logic [NumOpsWidth-1:0] op_q;
   logic [ShiftWidth-1:0]  shift_q;
   logic [IterWidth-1:0]   cnt_q;

   logic [HVDimension-1:0] acc_next;
   logic [HVDimension-1:0] rot;
   logic                   rot_left;
   logic                   capture;

   assign rot_left = (op_q == NumOpsWidth'(OP_ROL));

   hv_barrel_rot #(
      .HVDimension(HVDimension),
      .ShiftWidth (ShiftWidth)
   ) u_rot (
      .data(acc_q),
      .amt (shift_q),
      .dir (rot_left),
      .rot (rot)
   );

   always_comb begin
      acc_next = acc_q;
      case (op_q)
         NumOpsWidth'(OP_XOR):    acc_next = acc_q ^ b_q;
         NumOpsWidth'(OP_PASS_A): acc_next = acc_q;
         NumOpsWidth'(OP_PASS_B): acc_next = b_q;
         NumOpsWidth'(OP_ROR):    acc_next = rot;
         NumOpsWidth'(OP_ROL):    acc_next = rot;
         NumOpsWidth'(OP_AND):    acc_next = acc_q & b_q;
         NumOpsWidth'(OP_OR):     acc_next = acc_q | b_q;
         NumOpsWidth'(OP_NOT):    acc_next = ~acc_q;
         default:                 acc_next = acc_q;
      endcase
   end

   // Ready is combinational on out_ready_i so DONE can hand off and accept in one cycle.
   assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
   assign capture     = in_valid_i && in_ready_o;
   assign out_valid_o = (state_q == DONE);
   assign C_o         = acc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         b_q     <= '0;
         op_q    <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clr_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (capture) begin
                  acc_q   <= A_i;
                  b_q     <= B_i;
                  op_q    <= op_i;
                  shift_q <= shift_amt_i;
                  cnt_q   <= iter_i;
                  state_q <= BUSY;
               end else if (state_q == DONE && out_ready_i) begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               acc_q <= acc_next;
               if (cnt_q == '0) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hv_alu_iter_pe.sv
// Bench for hv_alu_iter_pe at 16-bit width: directed scenarios plus randomized traffic vs a transaction model.
module tb_hv_alu_iter_pe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic [2:0]  op_in = '0;
   logic [3:0]  sh_in = '0;
   logic [3:0]  it_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] c_out;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hv_alu_iter_pe #(
      .HVDimension(16),
      .NumOps     (8),
      .IterMax    (16)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (clr),
      .A_i        (a_in),
      .B_i        (b_in),
      .op_i       (op_in),
      .shift_amt_i(sh_in),
      .iter_i     (it_in),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .C_o        (c_out),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Single application of the op, written directly from the op table.
   function automatic logic [15:0] f1(input logic [15:0] acc, input logic [15:0] b,
                                      input logic [2:0] op, input int sh);
      logic [15:0] r;
      r = acc;
      case (op)
         3'd0: r = acc ^ b;
         3'd1: r = acc;
         3'd2: r = b;
         3'd3: for (int i = 0; i < 16; i++) r[i] = acc[(i + sh) % 16];
         3'd4: for (int i = 0; i < 16; i++) r[(i + sh) % 16] = acc[i];
         3'd5: r = acc & b;
         3'd6: r = acc | b;
         default: r = ~acc;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] apply_n(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op, input int sh, input int n);
      logic [15:0] r;
      r = a;
      for (int i = 0; i < n; i++) r = f1(r, b, op, sh);
      return r;
   endfunction

   // Transaction model: result is computed whole at acceptance, then released after iter+1 edges.
   bit          m_pending;
   bit          m_valid;
   int          m_left;
   logic [15:0] m_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending = 0;
         m_valid   = 0;
         m_left    = 0;
         m_res     = '0;
      end else if (clr) begin
         m_pending = 0;
         m_valid   = 0;
      end else if (m_pending) begin
         m_left--;
         if (m_left == 0) begin
            m_pending = 0;
            m_valid   = 1;
         end
      end else if (!m_valid || out_ready) begin
         m_valid = 0;
         if (in_valid) begin
            m_res     = apply_n(a_in, b_in, op_in, int'(sh_in), int'(it_in) + 1);
            m_left    = int'(it_in) + 1;
            m_pending = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
         chk("cyc_in_ready", {31'b0, in_ready},
             {31'b0, (!m_pending && !m_valid) || (m_valid && out_ready)});
         if (m_valid) chk("cyc_result", {16'b0, c_out}, {16'b0, m_res});
      end
   end

   // Called at posedge+1 with in_ready high; returns at posedge+1 after the accept edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [3:0] sh, input logic [3:0] it);
      a_in = a; b_in = b; op_in = op; sh_in = sh; it_in = it;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_in = $urandom; b_in = $urandom; op_in = 3'($urandom); sh_in = 4'($urandom); it_in = 4'($urandom);
   endtask

   // Counts edges from the accept edge (inclusive) until out_valid is seen.
   task automatic wait_valid(output int edges);
      edges = 1;
      while (!out_valid && edges < 64) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   int lat;

   initial begin
      #3;
      chk("reset_c", {16'b0, c_out}, 32'h0);
      chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

      // 1: single XOR
      send(16'h00F0, 16'h0F0F, 3'd0, 4'd0, 4'd0);
      wait_valid(lat);
      chk("t1_latency", lat, 32'd2);
      chk("t1_c", {16'b0, c_out}, 32'h0FFF);
      @(posedge clk); #1;
      chk("t1_idle_valid", {31'b0, out_valid}, 32'h0);
      chk("t1_idle_ready", {31'b0, in_ready}, 32'h1);

      // 2: rotate powers
      send(16'h0001, 16'h0, 3'd4, 4'd3, 4'd3);
      wait_valid(lat);
      chk("t2_rol_latency", lat, 32'd5);
      chk("t2_rol_c", {16'b0, c_out}, 32'h1000);
      idle(1);
      send(16'h0001, 16'h0, 3'd3, 4'd1, 4'd15);
      wait_valid(lat);
      chk("t2_ror_latency", lat, 32'd17);
      chk("t2_ror_c", {16'b0, c_out}, 32'h0001);
      idle(1);

      // 3: double XOR with output stall
      out_ready = 1'b0;
      send(16'h1234, 16'hFFFF, 3'd0, 4'd0, 4'd1);
      wait_valid(lat);
      chk("t3_latency", lat, 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t3_hold_c", {16'b0, c_out}, 32'h1234);
         chk("t3_hold_valid", {31'b0, out_valid}, 32'h1);
         chk("t3_hold_ready", {31'b0, in_ready}, 32'h0);
      end

      // 4: back-to-back accept from DONE
      out_ready = 1'b1;
      a_in = 16'h8000; b_in = 16'h0; op_in = 3'd3; sh_in = 4'd15; it_in = 4'd0;
      in_valid = 1'b1;
      #1;
      chk("t4_ready_comb", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t4_busy_valid", {31'b0, out_valid}, 32'h0);
      wait_valid(lat);
      chk("t4_latency", lat, 32'd2);
      chk("t4_c", {16'b0, c_out}, 32'h0001);
      idle(1);

      // 5: abort mid-BUSY
      send(16'hA5A5, 16'h5A5A, 3'd0, 4'd0, 4'd7);
      idle(2);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("t5_clr_ready", {31'b0, in_ready}, 32'h1);
      for (int i = 0; i < 10; i++) begin
         chk("t5_no_valid", {31'b0, out_valid}, 32'h0);
         @(posedge clk); #1;
      end
      send(16'h00FF, 16'h0F0F, 3'd5, 4'd0, 4'd2);
      wait_valid(lat);
      chk("t5_latency", lat, 32'd4);
      chk("t5_c", {16'b0, c_out}, 32'h000F);
      idle(1);

      // 6: async reset mid-BUSY
      send(16'h1357, 16'h2468, 3'd6, 4'd0, 4'd9);
      idle(2);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", {31'b0, out_valid}, 32'h0);
      chk("t6_rst_c", {16'b0, c_out}, 32'h0);
      chk("t6_rst_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      send(16'h00FF, 16'h0, 3'd7, 4'd0, 4'd2);
      wait_valid(lat);
      chk("t6_latency", lat, 32'd4);
      chk("t6_c", {16'b0, c_out}, 32'hFF00);
      idle(1);

      // Randomized traffic: inputs churn every cycle, checked by the model each cycle.
      for (int i = 0; i < 3000; i++) begin
         a_in      = 16'($urandom);
         b_in      = 16'($urandom);
         op_in     = 3'($urandom);
         sh_in     = 4'($urandom);
         it_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr       = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
